// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for the 5-stage core.
// Detects load-use and branch-operand hazards, produces forwarding selects,
// tracks data-memory waits with a timeout FSM and counts stall/flush events.
module hazard_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             JumpD,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             PC_Stall,
  output logic             IF_Stall,
  output logic             IF_Flush,
  output logic             ID_Flush,
  output logic             Freeze,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_MEMWAIT = 2'b01,
    ST_ERROR   = 2'b10
  } state_t;

  localparam logic [7:0]       TIMEOUT_C = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Register $0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != 5'd0);
  endfunction

  state_t     state_r;
  state_t     state_n_s;
  logic [7:0] wait_cnt_r;
  logic [7:0] wait_cnt_n_s;
  logic       mem_err_r;
  logic       mem_err_n_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic lw_stall_s;
  logic br_stall_s;
  logic hstall_s;
  logic miss_s;
  logic freeze_s;
  logic flush_evt_s;

  // Load-use and branch-operand hazard detection.
  always_comb begin
    lw_stall_s = MemtoRegE & (reg_match(RtE, RsD) | reg_match(RtE, RtD));
    br_stall_s = BranchD &
                 ((RegWriteE & (reg_match(WriteRegE, RsD) | reg_match(WriteRegE, RtD))) |
                  (MemtoRegM & (reg_match(WriteRegM, RsD) | reg_match(WriteRegM, RtD))));
    hstall_s   = lw_stall_s | br_stall_s;
    miss_s     = MemReqM & ~MemReadyM;
    freeze_s   = miss_s | (state_r == ST_ERROR);
  end

  // EX operand A select: MEM result wins over WB result.
  always_comb begin
    if (RegWriteM && reg_match(WriteRegM, RsE)) begin
      ForwardAE = 2'b10;
    end else if (RegWriteW && reg_match(WriteRegW, RsE)) begin
      ForwardAE = 2'b01;
    end else begin
      ForwardAE = 2'b00;
    end
  end

  // EX operand B select: MEM result wins over WB result.
  always_comb begin
    if (RegWriteM && reg_match(WriteRegM, RtE)) begin
      ForwardBE = 2'b10;
    end else if (RegWriteW && reg_match(WriteRegW, RtE)) begin
      ForwardBE = 2'b01;
    end else begin
      ForwardBE = 2'b00;
    end
  end

  // ID comparator operands take the MEM result on a match.
  always_comb begin
    ForwardAD = RegWriteM & reg_match(WriteRegM, RsD);
    ForwardBD = RegWriteM & reg_match(WriteRegM, RtD);
  end

  // Pipeline control priority: reset, freeze, hazard stall, redirect flush.
  // A redirect hidden behind a stall is re-presented once ID advances.
  always_comb begin
    PC_Stall    = 1'b0;
    IF_Stall    = 1'b0;
    IF_Flush    = 1'b0;
    ID_Flush    = 1'b0;
    Freeze      = 1'b0;
    flush_evt_s = 1'b0;
    if (rst) begin
      IF_Flush = 1'b1;
      ID_Flush = 1'b1;
    end else if (freeze_s) begin
      PC_Stall = 1'b1;
      IF_Stall = 1'b1;
      Freeze   = 1'b1;
    end else if (hstall_s) begin
      PC_Stall = 1'b1;
      IF_Stall = 1'b1;
      ID_Flush = 1'b1;
    end else if (PCSrcD || JumpD) begin
      IF_Flush    = 1'b1;
      flush_evt_s = 1'b1;
    end else begin
      flush_evt_s = 1'b0;
    end
  end

  // Memory-wait FSM next state, wait counter and sticky error.
  always_comb begin
    state_n_s    = state_r;
    wait_cnt_n_s = wait_cnt_r;
    mem_err_n_s  = mem_err_r;
    case (state_r)
      ST_RUN: begin
        if (miss_s) begin
          state_n_s    = ST_MEMWAIT;
          wait_cnt_n_s = 8'd1;
        end else begin
          wait_cnt_n_s = 8'd0;
        end
      end
      ST_MEMWAIT: begin
        if (MemReadyM) begin
          state_n_s    = ST_RUN;
          wait_cnt_n_s = 8'd0;
        end else if (wait_cnt_r == TIMEOUT_C) begin
          state_n_s   = ST_ERROR;
          mem_err_n_s = 1'b1;
        end else begin
          wait_cnt_n_s = wait_cnt_r + 8'd1;
        end
      end
      ST_ERROR: begin
        state_n_s = ST_ERROR;
      end
      default: begin
        state_n_s    = ST_RUN;
        wait_cnt_n_s = 8'd0;
      end
    endcase
  end

  // FSM state, wait counter and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= 8'd0;
      mem_err_r  <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      wait_cnt_r <= wait_cnt_n_s;
      mem_err_r  <= mem_err_n_s;
    end
  end

  // Profiling counters: unfrozen hazard stalls and redirect flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (hstall_s && !freeze_s) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_evt_s) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign mem_err   = mem_err_r;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule
